// File: rtl/sc_dec_pkg.sv
// Shared types and sizing for the SC polar decoder core.
package sc_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    OUTPUT = 2'd3
  } seq_state_e;

  localparam int unsigned N_LOG2_DEF = 3;
  localparam int unsigned P_LOG2_DEF = 1;
  localparam int unsigned N          = 2 ** N_LOG2_DEF;
  localparam int unsigned BEATS      = 2 ** (N_LOG2_DEF - P_LOG2_DEF);

  // Stage index width; kept at least 1 so a port can always be declared.
  function automatic int unsigned sw_width(input int unsigned log_n);
    return (log_n < 2) ? 1 : $clog2(log_n);
  endfunction

endpackage

// File: rtl/sc_frame_buffer.sv
// Decoded-frame storage: one bit written per decision, frozen positions forced to 0.
module sc_frame_buffer
  import sc_dec_pkg::*;
#(
  parameter int unsigned n = N_LOG2_DEF
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [n-1:0]    wr_idx,
  input  logic [2**n-1:0] frozen,
  input  logic            bit_in,
  output logic [2**n-1:0] bits
);

  always_ff @(posedge clk) begin
    if (clear) begin
      bits <= '0;
    end else if (wr_en) begin
      bits[wr_idx] <= frozen[wr_idx] ? 1'b0 : bit_in;
    end
  end

endmodule

// File: rtl/sc_decode_sequencer.sv
// Frame sequencer for the SC polar decoder: load LLRs, run PEs, collect decisions, hand off frame.
// Optional SC_SEQ_CYCLE_COUNT_EN adds a saturating run_cycles counter output.
module sc_decode_sequencer
  import sc_dec_pkg::*;
#(
  parameter int unsigned n  = N_LOG2_DEF,
  parameter int unsigned p  = P_LOG2_DEF,
  parameter int unsigned SW = sw_width(n)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2**n-1:0] frozen_mask,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            llr_wr_en,
  output logic [n-p-1:0]  llr_wr_addr,
  input  logic [SW-1:0]   stage_index,
  input  logic [n-p-1:0]  exe_index,
  output logic            pe_en,
  output logic [n-1:0]    bit_index,
  input  logic            u_hat,
  output logic            bit_decide,
  output logic [2**n-1:0] out_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
`ifdef SC_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]     run_cycles
`endif
);

  localparam int unsigned FRAME_LEN = 2 ** n;
  localparam int unsigned BEAT_CNT  = 2 ** (n - p);
  localparam int unsigned AW        = n - p;
  localparam logic [n-1:0]  LAST_BIT  = n'(FRAME_LEN - 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEAT_CNT - 1);

  seq_state_e      state;
  logic [2**n-1:0] frozen_r;
  logic [AW-1:0]   wr_addr;
  logic [n-1:0]    bit_idx;
  logic            done_r;
  logic            decide;

  // exe_index is only consumed by the PE array; the sequencer does not need it.
  logic unused_exe;
  assign unused_exe = ^exe_index;

  assign decide = (state == RUN) && (stage_index == '0);

  // Sequencer FSM with its address, bit position and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      frozen_r <= '0;
      wr_addr  <= '0;
      bit_idx  <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            frozen_r <= frozen_mask;
            bit_idx  <= '0;
            wr_addr  <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (wr_addr == LAST_BEAT) begin
              state   <= RUN;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end
        RUN: begin
          // Last index is held so the stage controller sees it through OUTPUT and IDLE.
          if (stage_index == '0) begin
            if (bit_idx == LAST_BIT) begin
              state <= OUTPUT;
            end else begin
              bit_idx <= bit_idx + n'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sc_frame_buffer #(.n(n)) u_frame_buffer (
    .clk    (clk),
    .clear  (rst),
    .wr_en  (decide),
    .wr_idx (bit_idx),
    .frozen (frozen_r),
    .bit_in (u_hat),
    .bits   (out_bits)
  );

  assign in_ready    = (state == LOAD);
  assign llr_wr_en   = in_valid && (state == LOAD);
  assign llr_wr_addr = wr_addr;
  assign pe_en       = (state == RUN);
  assign bit_index   = bit_idx;
  assign bit_decide  = decide;
  assign out_valid   = (state == OUTPUT);
  assign busy        = (state != IDLE);
  assign done        = done_r;

`ifdef SC_SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_cnt;

  // Counts enabled PE cycles of the current frame, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cyc_cnt <= '0;
    end else if ((state == RUN) && (cyc_cnt != 16'hFFFF)) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end

  assign run_cycles = cyc_cnt;
`endif

endmodule

// File: tb/tb_sc_decode_sequencer.sv
// Self-checking bench for sc_decode_sequencer (n=3, p=1): vector table plus reset/back-to-back sequences.
module tb_sc_decode_sequencer;

  localparam int RUN_LEN = 14;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, u_hat, out_ready;
  logic [7:0] frozen_mask;
  logic [1:0] stage_index;
  logic [1:0] exe_index;
  logic       in_ready, llr_wr_en, pe_en, bit_decide, out_valid, busy, done;
  logic [1:0] llr_wr_addr;
  logic [2:0] bit_index;
  logic [7:0] out_bits;
`ifdef SC_SEQ_CYCLE_COUNT_EN
  logic [15:0] run_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int sb_q[$];
  logic [7:0] frame_q[$];

  typedef struct {
    logic [7:0] mask;
    logic [7:0] uvals;
    logic [4:0] vpat;
    int         stall;
    bit         b2b;
    bit         glitch;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sc_decode_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frozen_mask (frozen_mask),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .llr_wr_en   (llr_wr_en),
    .llr_wr_addr (llr_wr_addr),
    .stage_index (stage_index),
    .exe_index   (exe_index),
    .pe_en       (pe_en),
    .bit_index   (bit_index),
    .u_hat       (u_hat),
    .bit_decide  (bit_decide),
    .out_bits    (out_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
`ifdef SC_SEQ_CYCLE_COUNT_EN
    ,
    .run_cycles  (run_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a frame from IDLE and stream 4 beats using the gap pattern (LSB first, then all 1s).
  task automatic load_frame(input logic [7:0] mask, input logic [4:0] vpat);
    int accepted = 0;
    int cyc = 0;
    start = 1'b1;
    frozen_mask = mask;
    #1;
    chk("idle_in_ready", in_ready, 0);
    step();
    start = 1'b0;
    frozen_mask = ~mask;
    chk("start_busy", busy, 1);
    chk("start_bit_index", bit_index, 0);
    chk("start_done_low", done, 0);
    while (accepted < 4 && cyc < 50) begin
      in_valid = (cyc < 5) ? vpat[cyc] : 1'b1;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_wr_en", llr_wr_en, in_valid);
      chk("load_pe_en", pe_en, 0);
      if (in_valid) begin
        chk("load_addr", llr_wr_addr, accepted);
        accepted++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (accepted < 4) begin
      errors++;
      $display("FAIL load_timeout: got %0d beats expected 4", accepted);
    end
    chk("run_entry_pe_en", pe_en, 1);
    chk("run_entry_addr_wrap", llr_wr_addr, 0);
    chk("run_entry_in_ready", in_ready, 0);
  endtask

  // Drive stage sequences per bit: bit0 2,2,1,0; odd bits 0; other even bits 1,0.
  task automatic run_bits(input logic [7:0] uvals, input bit glitch, input int rst_at,
                          output bit aborted);
    int decisions = 0;
    aborted = 1'b0;
    for (int b = 0; b < 8; b++) begin
      int len;
      len = (b == 0) ? 4 : ((b % 2 == 1) ? 1 : 2);
      for (int k = 0; k < len; k++) begin
        if (b == 0) stage_index = (k < 2) ? 2'd2 : 2'(3 - k);
        else        stage_index = 2'(len - 1 - k);
        u_hat = uvals[b];
        start = glitch && (b == 3) && (k == 0);
        if (stage_index == 2'd0) sb_q.push_back(b);
        if (stage_index == 2'd0 && decisions == rst_at) rst = 1'b1;
        #1;
        chk("run_pe_en", pe_en, 1);
        chk("run_decide", bit_decide, stage_index == 2'd0);
        if (bit_decide) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL decide_unexpected: got bit_index %0d expected none", bit_index);
          end else begin
            chk("decide_idx", bit_index, sb_q.pop_front());
          end
          decisions++;
        end else begin
          chk("hold_idx", bit_index, b);
        end
        step();
        if (rst) begin
          rst = 1'b0;
          start = 1'b0;
          chk("rst_busy", busy, 0);
          chk("rst_bit_index", bit_index, 0);
          chk("rst_pe_en", pe_en, 0);
          chk("rst_out_valid", out_valid, 0);
          chk("rst_in_ready", in_ready, 0);
          chk("rst_out_bits", out_bits, 0);
`ifdef SC_SEQ_CYCLE_COUNT_EN
          chk("rst_run_cycles", run_cycles, 0);
`endif
          aborted = 1'b1;
          stage_index = 2'd2;
          return;
        end
      end
    end
    start = 1'b0;
    stage_index = 2'd2;
    u_hat = 1'b0;
    chk("sb_drain", sb_q.size(), 0);
  endtask

  // Hand the frame out under backpressure and check the scoreboard entry.
  task automatic out_phase(input int stall, input bit b2b);
    logic [7:0] exp_bits;
    int waited = 0;
    exp_bits = frame_q.pop_front();
    while (!out_valid && waited < 20) begin
      step();
      waited++;
    end
    chk("out_valid", out_valid, 1);
    chk("out_pe_en", pe_en, 0);
    chk("out_bit_index", bit_index, 7);
    chk("out_bits", out_bits, exp_bits);
`ifdef SC_SEQ_CYCLE_COUNT_EN
    chk("out_run_cycles", run_cycles, RUN_LEN);
`endif
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_bits", out_bits, exp_bits);
      chk("stall_done", done, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("handoff_done", done, 1);
    chk("handoff_busy", busy, 0);
    chk("handoff_valid", out_valid, 0);
    chk("handoff_bit_index", bit_index, 7);
    chk("handoff_bits_kept", out_bits, exp_bits);
    if (!b2b) begin
      step();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_bit_index", bit_index, 7);
    end
  endtask

  initial begin
    bit aborted;
    vecs[0] = '{mask: 8'b0001_0111, uvals: 8'hFF, vpat: 5'b11101, stall: 5, b2b: 0, glitch: 0,
                expected: 8'b1110_1000};
    vecs[1] = '{mask: 8'h00, uvals: 8'hA5, vpat: 5'b11111, stall: 0, b2b: 1, glitch: 0,
                expected: 8'hA5};
    vecs[2] = '{mask: 8'hF0, uvals: 8'hFF, vpat: 5'b10011, stall: 2, b2b: 0, glitch: 1,
                expected: 8'h0F};
    vecs[3] = '{mask: 8'h81, uvals: 8'hBD, vpat: 5'b01010, stall: 1, b2b: 0, glitch: 0,
                expected: 8'h3C};
    vecs[4] = '{mask: 8'hFF, uvals: 8'h5A, vpat: 5'b11111, stall: 0, b2b: 0, glitch: 0,
                expected: 8'h00};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    u_hat = 1'b1;
    out_ready = 1'b0;
    frozen_mask = 8'h00;
    stage_index = 2'd0;
    exe_index = 2'd0;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_wr_en", llr_wr_en, 0);
    chk("reset_addr", llr_wr_addr, 0);
    chk("reset_pe_en", pe_en, 0);
    chk("reset_bit_index", bit_index, 0);
    chk("reset_bit_decide", bit_decide, 0);
    chk("reset_out_bits", out_bits, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    stage_index = 2'd2;
    step();

    for (int i = 0; i < 5; i++) begin
      frame_q.push_back(vecs[i].expected);
      load_frame(vecs[i].mask, vecs[i].vpat);
      run_bits(vecs[i].uvals, vecs[i].glitch, -1, aborted);
      chk("vec_not_aborted", aborted, 0);
      out_phase(vecs[i].stall, vecs[i].b2b);
    end

    // Reset on the third decision discards the frame.
    frame_q.push_back(8'hC3);
    load_frame(8'h00, 5'b11111);
    run_bits(8'hC3, 1'b0, 2, aborted);
    chk("midrst_aborted", aborted, 1);
    void'(frame_q.pop_back());
    sb_q.delete();
    step();
    chk("midrst_idle_busy", busy, 0);

    // A clean frame after the reset decodes normally.
    frame_q.push_back(8'h96);
    load_frame(8'h00, 5'b10101);
    run_bits(8'h96, 1'b0, -1, aborted);
    out_phase(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
